// File: rtl/fan_ctrl_if.sv
// Signal bundle between the fan controller, its software/tick sources and the PWM/tach block.
interface fan_ctrl_if;
  logic        tsc_1ppms;
  logic        fan_auto;
  logic [7:0]  fan_man_pct;
  logic [19:0] fan_tgt_uspr;
  logic [19:0] fan_uspr;
  logic [7:0]  fan_pct;
  logic        fan_stall;
  logic        fan_kick;

  modport master (
    output tsc_1ppms, fan_auto, fan_man_pct, fan_tgt_uspr, fan_uspr,
    input  fan_pct, fan_stall, fan_kick
  );

  modport slave (
    input  tsc_1ppms, fan_auto, fan_man_pct, fan_tgt_uspr, fan_uspr,
    output fan_pct, fan_stall, fan_kick
  );
endinterface

// File: rtl/fan_ctrl.sv
// Closed-loop fan duty controller: integral step toward a tach-period setpoint,
// with manual override, stall detection and full-speed kick recovery.
module fan_ctrl #(
  parameter int unsigned UPDATE_MS   = 100,
  parameter int unsigned GAIN_SHIFT  = 6,
  parameter int unsigned MAX_STEP    = 16,
  parameter int unsigned DEADBAND    = 32,
  parameter logic [7:0]  MIN_PCT     = 8'h30,
  parameter int unsigned STALL_LIMIT = 3,
  parameter int unsigned KICK_MS     = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  fan_ctrl_if.slave  bus
);

  localparam int unsigned UW = 20;
  localparam int unsigned EW = UW + 1;
  localparam int unsigned PW = 8;
  localparam int unsigned IW = (UPDATE_MS > 1) ? $clog2(UPDATE_MS) : 1;
  localparam int unsigned KW = (KICK_MS > 1) ? $clog2(KICK_MS) : 1;
  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_STEP, S_KICK} state_t;

  state_t         state;
  logic [IW-1:0]  ms_cnt;
  logic [KW-1:0]  kick_cnt;
  logic [SW-1:0]  stall_cnt;
  logic [UW-1:0]  uspr_q;
  logic [UW-1:0]  tgt_q;
  logic [EW-1:0]  abs_err_q;
  logic           err_neg_q;
  logic [PW-1:0]  pct_q;
  logic           stall_q;
  logic           kick_q;

  logic           upd_c;
  logic [EW-1:0]  err_c;
  logic [EW-1:0]  abs_err_c;
  logic [EW-1:0]  step_raw_c;
  logic [PW-1:0]  step_c;
  logic [PW:0]    sum_c;
  logic [PW:0]    diff_c;
  logic [PW-1:0]  up_pct_c;
  logic [PW-1:0]  dn_pct_c;
  logic           stall_c;
  logic           valid_c;
  logic           change_c;
  logic [SW-1:0]  stall_nxt_c;

  assign upd_c = bus.tsc_1ppms && (ms_cnt == IW'(UPDATE_MS - 1));

  // Free-running update interval, independent of mode and state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_cnt <= '0;
    end else if (bus.tsc_1ppms) begin
      ms_cnt <= upd_c ? '0 : ms_cnt + IW'(1);
    end
  end

  // Error magnitude and bounded step from the latched sample.
  always_comb begin
    err_c       = {1'b0, uspr_q} - {1'b0, tgt_q};
    abs_err_c   = err_c[EW-1] ? (~err_c + EW'(1)) : err_c;
    step_raw_c  = abs_err_q >> GAIN_SHIFT;
    if (step_raw_c == '0) begin
      step_c = PW'(1);
    end else if (step_raw_c > EW'(MAX_STEP)) begin
      step_c = PW'(MAX_STEP);
    end else begin
      step_c = step_raw_c[PW-1:0];
    end
    sum_c       = {1'b0, pct_q} + {1'b0, step_c};
    diff_c      = {1'b0, pct_q} - {1'b0, step_c};
    up_pct_c    = sum_c[PW] ? 8'hFF : sum_c[PW-1:0];
    dn_pct_c    = (diff_c[PW] || (diff_c[PW-1:0] < MIN_PCT)) ? MIN_PCT : diff_c[PW-1:0];
    stall_c     = (uspr_q == 20'hFFFFF);
    valid_c     = (uspr_q != '0) && !stall_c;
    change_c    = valid_c && (tgt_q != '0) && (abs_err_q > EW'(DEADBAND));
    stall_nxt_c = (stall_cnt == SW'(STALL_LIMIT)) ? stall_cnt : stall_cnt + SW'(1);
  end

  // Control sequencer; manual mode overrides everything except the interval counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      kick_cnt  <= '0;
      stall_cnt <= '0;
      uspr_q    <= '0;
      tgt_q     <= '0;
      abs_err_q <= '0;
      err_neg_q <= 1'b0;
      pct_q     <= 8'hFF;
      stall_q   <= 1'b0;
      kick_q    <= 1'b0;
    end else if (!bus.fan_auto) begin
      state  <= S_IDLE;
      pct_q  <= bus.fan_man_pct;
      kick_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (upd_c) begin
            uspr_q <= bus.fan_uspr;
            tgt_q  <= bus.fan_tgt_uspr;
            state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          abs_err_q <= abs_err_c;
          err_neg_q <= err_c[EW-1];
          state     <= S_STEP;
          if (stall_c) begin
            stall_cnt <= stall_nxt_c;
            if (stall_nxt_c == SW'(STALL_LIMIT)) begin
              stall_q  <= 1'b1;
              pct_q    <= 8'hFF;
              kick_q   <= 1'b1;
              kick_cnt <= '0;
              state    <= S_KICK;
            end
          end
        end
        S_STEP: begin
          if (valid_c) begin
            stall_cnt <= '0;
            stall_q   <= 1'b0;
          end
          if (change_c) begin
            pct_q <= err_neg_q ? dn_pct_c : up_pct_c;
          end
          state <= S_IDLE;
        end
        S_KICK: begin
          pct_q <= 8'hFF;
          if (bus.tsc_1ppms) begin
            if (kick_cnt == KW'(KICK_MS - 1)) begin
              kick_q    <= 1'b0;
              stall_cnt <= '0;
              state     <= S_IDLE;
            end else begin
              kick_cnt <= kick_cnt + KW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.fan_pct   = pct_q;
  assign bus.fan_stall = stall_q;
  assign bus.fan_kick  = kick_q;

endmodule

// File: tb/tb_fan_ctrl.sv
// Bench for fan_ctrl: directed scenarios plus randomized traffic against a
// millisecond-level behavioural model of the controller.
module tb_fan_ctrl;

  localparam int unsigned UPD = 2;
  localparam int unsigned KMS = 4;
  localparam int unsigned GAP = 4;
  localparam int          MINP = 8'h30;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fan_ctrl_if bus ();

  fan_ctrl #(.UPDATE_MS(UPD), .KICK_MS(KMS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model state: tick phase, duty, stall bookkeeping, kick time remaining.
  int m_ms, m_pct, m_scnt, m_kleft;
  bit m_stall, m_kick;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ms = 0; m_pct = 255; m_scnt = 0; m_kleft = 0; m_stall = 0; m_kick = 0;
  endtask

  // One millisecond of controller behaviour; stepped flags a normal control step.
  task automatic model_tick(output bit upd, output bit stepped);
    int u, t, err, ae, step;
    upd = (m_ms == UPD - 1);
    m_ms = upd ? 0 : m_ms + 1;
    stepped = 0;
    if (!bus.fan_auto) begin
      m_pct = int'(bus.fan_man_pct);
      m_kick = 0;
      return;
    end
    if (m_kick) begin
      m_kleft--;
      if (m_kleft == 0) begin
        m_kick = 0;
        m_scnt = 0;
      end
      return;
    end
    if (!upd) return;
    u = int'(bus.fan_uspr);
    t = int'(bus.fan_tgt_uspr);
    if (u == 20'hFFFFF) begin
      m_scnt = (m_scnt + 1 > 3) ? 3 : m_scnt + 1;
      if (m_scnt == 3) begin
        m_stall = 1; m_kick = 1; m_kleft = KMS; m_pct = 255;
      end
      return;
    end
    if (u == 0) return;
    m_scnt = 0;
    m_stall = 0;
    if (t == 0) return;
    err = u - t;
    ae = (err < 0) ? -err : err;
    if (ae <= 32) return;
    step = ae / 64;
    if (step < 1) step = 1;
    if (step > 16) step = 16;
    if (err > 0) m_pct = (m_pct + step > 255) ? 255 : m_pct + step;
    else         m_pct = (m_pct - step < MINP) ? MINP : m_pct - step;
    stepped = 1;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_pct"},   bus.fan_pct,   m_pct);
    check_eq({tag, "_stall"}, bus.fan_stall, m_stall);
    check_eq({tag, "_kick"},  bus.fan_kick,  m_kick);
  endtask

  // Called just after a negedge; issues one ms tick and checks step latency.
  task automatic tick();
    bit upd, stepped;
    int old;
    old = m_pct;
    model_tick(upd, stepped);
    bus.tsc_1ppms = 1'b1;
    @(negedge clk);
    bus.tsc_1ppms = 1'b0;
    if (stepped) begin
      @(negedge clk);
      check_eq("lat_clk2", bus.fan_pct, old);
      @(negedge clk);
      check_eq("lat_clk3", bus.fan_pct, m_pct);
    end
    repeat (GAP) @(negedge clk);
    check_outputs("tick");
  endtask

  task automatic do_update();
    repeat (UPD - m_ms) tick();
  endtask

  task automatic set_inputs(input bit auto_v, input int man, input int tgt, input int uspr);
    bus.fan_auto     = auto_v;
    bus.fan_man_pct  = 8'(man);
    bus.fan_tgt_uspr = 20'(tgt);
    bus.fan_uspr     = 20'(uspr);
    if (!auto_v) begin
      m_pct = man;
      m_kick = 0;
    end
    @(negedge clk);
    check_outputs("set");
  endtask

  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_pct",   bus.fan_pct,   8'hFF);
    check_eq("rst_stall", bus.fan_stall, 1'b0);
    check_eq("rst_kick",  bus.fan_kick,  1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int r, tg, us;
    rst_n = 1'b0;
    bus.tsc_1ppms = 1'b0;
    bus.fan_auto = 1'b1;
    bus.fan_man_pct = 8'h00;
    bus.fan_tgt_uspr = 20'd20000;
    bus.fan_uspr = 20'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("init_pct",   bus.fan_pct,   8'hFF);
    check_eq("init_stall", bus.fan_stall, 1'b0);
    check_eq("init_kick",  bus.fan_kick,  1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Slow-down: 15000 vs 20000 clamps to a 16-count step.
    set_inputs(1, 0, 20000, 15000);
    do_update();
    check_eq("slow_1", bus.fan_pct, 8'hEF);
    do_update();
    check_eq("slow_2", bus.fan_pct, 8'hDF);

    // Speed-up by the minimum step, then inside the deadband.
    set_inputs(0, 'h80, 20000, 20100);
    set_inputs(1, 'h80, 20000, 20100);
    do_update();
    check_eq("up_1", bus.fan_pct, 8'h81);
    set_inputs(1, 0, 20000, 20020);
    do_update();
    check_eq("deadband", bus.fan_pct, 8'h81);

    // Unusable samples hold the duty.
    set_inputs(1, 0, 20000, 0);
    do_update();
    check_eq("no_meas", bus.fan_pct, 8'h81);
    set_inputs(1, 0, 0, 30000);
    do_update();
    check_eq("no_tgt", bus.fan_pct, 8'h81);

    // Floor and ceiling.
    set_inputs(0, 'h38, 20000, 10000);
    set_inputs(1, 'h38, 20000, 10000);
    do_update();
    check_eq("floor_1", bus.fan_pct, 8'h30);
    do_update();
    check_eq("floor_2", bus.fan_pct, 8'h30);
    set_inputs(0, 'hF8, 20000, 40000);
    set_inputs(1, 'hF8, 20000, 40000);
    do_update();
    check_eq("ceiling", bus.fan_pct, 8'hFF);

    // Stall -> kick -> recovery.
    set_inputs(1, 0, 20000, 20'hFFFFF);
    repeat (3) do_update();
    check_eq("stall_set", bus.fan_stall, 1'b1);
    check_eq("kick_set",  bus.fan_kick,  1'b1);
    repeat (KMS) tick();
    check_eq("kick_done", bus.fan_kick, 1'b0);
    check_eq("kick_pct",  bus.fan_pct,  8'hFF);
    set_inputs(1, 0, 20000, 25000);
    do_update();
    check_eq("stall_clr", bus.fan_stall, 1'b0);
    check_eq("stall_pct", bus.fan_pct,   8'hFF);

    // Manual override, kick abort, bumpless return.
    set_inputs(0, 'h40, 20000, 25000);
    check_eq("man_pct", bus.fan_pct, 8'h40);
    set_inputs(1, 'h40, 20000, 20'hFFFFF);
    repeat (3) do_update();
    check_eq("kick_again", bus.fan_kick, 1'b1);
    set_inputs(0, 'h40, 20000, 20'hFFFFF);
    check_eq("kick_abort", bus.fan_kick, 1'b0);
    check_eq("abort_pct",  bus.fan_pct,  8'h40);
    set_inputs(1, 'h40, 20000, 15000);
    do_update();
    check_eq("bumpless", bus.fan_pct, 8'h30);

    // Reset in the middle of a kick, then the first update two ticks later.
    set_inputs(1, 0, 20000, 20'hFFFFF);
    repeat (3) do_update();
    tick();
    check_eq("pre_rst_kick", bus.fan_kick, 1'b1);
    async_reset();
    set_inputs(1, 0, 20000, 15000);
    tick();
    check_eq("post_rst_1", bus.fan_pct, 8'hFF);
    tick();
    check_eq("post_rst_2", bus.fan_pct, 8'hEF);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 99));
      tg = (r < 10) ? 0 : int'($urandom_range(5000, 60000));
      r  = int'($urandom_range(0, 99));
      if (r < 5)       us = 0;
      else if (r < 25) us = 'hFFFFF;
      else if (r < 60) us = ((tg == 0) ? 20000 : tg) + int'($urandom_range(0, 400)) - 200;
      else             us = int'($urandom_range(1, 100000));
      if (us < 0) us = 0;
      r = int'($urandom_range(0, 99));
      set_inputs(r >= 15, int'($urandom_range(0, 255)), tg, us);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fan_ctrl.md
Name: fan_ctrl

Overview:
Closed-loop fan speed controller that closes the loop around the fan PWM/tach block.
- Consumes the measured tach period `fan_uspr` (microseconds per tach rising edge, saturates at 20'hFFFFF, 0 until the first pulse).
- Produces the `fan_pct` duty command that the PWM block consumes.
- Runs an integral-style step controller once per update interval toward a software setpoint period.
- Provides manual override, stall detection and a full-speed kick recovery.

Parameters:
- UPDATE_MS, 100: number of `tsc_1ppms` ticks per control update.
- GAIN_SHIFT, 6: right shift applied to |error| (us) to form the step size.
- MAX_STEP, 16: maximum duty change per update (counts).
- DEADBAND, 32: |error| in us at or below which no change is made.
- MIN_PCT, 8'h30: floor for the duty in auto mode.
- STALL_LIMIT, 3: consecutive stalled samples before a kick.
- KICK_MS, 2000: duration of the full-speed kick in ms ticks.

Ports:
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  system clock; single clock domain
- tsc_1ppms  in  1  one-clock pulse per millisecond
- fan_auto  in  1  1 = closed loop, 0 = manual
- fan_man_pct  in  8  manual duty command
- fan_tgt_uspr  in  20  setpoint tach period, us; 0 = hold
- fan_uspr  in  20  measured tach period, us
- fan_pct  out  8  duty command to the PWM block
- fan_stall  out  1  stall status
- fan_kick  out  1  high while a kick is in progress

Behaviour:
Reset:
- Outputs: `fan_pct` = 8'hFF (safe full speed), `fan_stall` = 0, `fan_kick` = 0.
- Internal: state = S_IDLE, interval counter = 0, stall count = 0, kick counter = 0.

Interval counter:
- Increments on `tsc_1ppms` in every state and mode.
- On the tick where the count equals UPDATE_MS-1 it wraps to 0 and raises a one-clock `upd` strobe.

State machine:
- S_IDLE: on `upd` with `fan_auto`=1, latch `fan_uspr` and `fan_tgt_uspr`, then go to S_EVAL.
- S_EVAL:
  - err = {1'b0,fan_uspr} - {1'b0,tgt}, 21-bit signed; abs_err registered.
  - stall = (uspr == 20'hFFFFF); stall count saturates at STALL_LIMIT.
  - If stall count reaches STALL_LIMIT: set `fan_stall` = 1, go to S_KICK.
  - Otherwise go to S_STEP.
- S_STEP: apply the step rules below; `fan_pct` is registered on exit. Always returns to S_IDLE.
  - No change if uspr == 0 (no measurement), tgt == 0, stall, or abs_err <= DEADBAND.
  - step = abs_err >> GAIN_SHIFT, clamped to [1, MAX_STEP].
  - err > 0 (fan too slow): fan_pct = min(fan_pct + step, 255), computed 9-bit.
  - err < 0: fan_pct = max(fan_pct - step, MIN_PCT); also applies if fan_pct < MIN_PCT on entry.
  - A non-stall valid sample clears the stall count and `fan_stall`.
- S_KICK:
  - On entry: `fan_pct` = FF, `fan_kick` = 1, kick counter cleared.
  - Counts `tsc_1ppms`; at KICK_MS ticks: `fan_kick` = 0, stall count = 0, go to S_IDLE.
  - `fan_pct` stays FF; `fan_stall` stays 1 until the next valid non-stall sample.

Latency:
- `fan_pct` changes on the 3rd rising clk after the `tsc_1ppms` cycle that produces `upd` (S_IDLE→S_EVAL→S_STEP→reg).

Manual mode (`fan_auto`=0):
- `fan_pct` <= `fan_man_pct` every clock (1-clock latency).
- FSM forced to S_IDLE: any kick aborts and `fan_kick` clears.
- Stall count is frozen; `fan_stall` holds.

Mode switches:
- Manual→auto is bumpless: control resumes from the current `fan_pct` at the next `upd`.
- `fan_auto` dropping while in S_EVAL/S_STEP: the manual value wins and the step is discarded.

Boundary cases:
- `upd` can only occur in S_IDLE or S_KICK, since each update takes 2 clocks and ticks are 1 ms apart.
- `upd` during S_KICK is ignored; the interval counter keeps running.
- Reset mid-operation returns everything to the reset values above.

Test Plan:
Unless noted, the bench runs with UPDATE_MS=2, KICK_MS=4, and `fan_tgt_uspr`=20000.
- Reset check: assert `rst_n` low mid-kick → `fan_pct`=FF, `fan_stall`=0, `fan_kick`=0 asynchronously; after release, first update is 2 ms later.
- Slow-down step: auto, start FF, `fan_uspr`=15000 → err -5000, step clamped to 16 → `fan_pct` FF→EF→DF on successive updates, each 3 clk after `upd`.
- Speed-up step: `fan_pct`=0x80, `fan_uspr`=20100 → +1 (0x81); then `fan_uspr`=20020 (deadband) → stays 0x81.
- Bad samples: `fan_uspr`=0 → no change; `fan_tgt_uspr`=0 → no change.
- Floor and ceiling: `fan_pct`=0x38, `fan_uspr`=10000 → 0x30 and stays 0x30; `fan_pct`=0xF8, `fan_uspr`=40000 → FF, not wrapped.
- Stall/kick: `fan_uspr`=FFFFF for 3 updates → `fan_stall`=1, `fan_kick`=1, `fan_pct`=FF held 4 ms, then `fan_kick`=0; next `fan_uspr`=25000 → `fan_stall`=0, `fan_pct` FF (saturated).
- Manual override: `fan_auto`=0, `fan_man_pct`=0x40 → `fan_pct`=0x40 next clk, and dropping `fan_auto` mid-kick aborts the kick (`fan_kick`=0); return to auto with `fan_uspr`=15000 → 0x30 (0x40-16).
